// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI slave and its RAM stage: command encodings and data width.
package spi_ram_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port byte array: synchronous write, combinational read.
// Addresses outside MEM_DEPTH drop writes and read back zero.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [2**IDX_W];
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  // Range check and zero-on-out-of-range read path
  always_comb begin
    idx      = IDX_W'(addr);
    in_range = (32'(addr) < 32'(MEM_DEPTH));
    if (in_range) begin
      rdata = mem_q[idx];
    end else begin
      rdata = {DATA_W{1'b0}};
    end
  end

  // Array write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem_q[idx] <= wdata;
    end
  end

endmodule

// File: rtl/spi_ram.sv
// RAM stage behind the SPI slave: decodes 2-bit commands, keeps the write/read
// address registers and returns read bytes with a one-cycle tx_valid strobe.
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid
);

  cmd_t                 cmd;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_W-1:0]    mem_rdata;

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    if (32'(a) == 32'(MEM_DEPTH - 1)) begin
      return {ADDR_SIZE{1'b0}};
    end else begin
      return a + ADDR_SIZE'(1);
    end
  endfunction

  assign cmd = cmd_t'(din[9:8]);

  // Command decode; the array port is steered to wr_addr only for data writes
  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = rd_addr_q;
    if (rx_valid && !rst) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr_d = din[ADDR_SIZE-1:0];
        CMD_WR_DATA: begin
          mem_addr = wr_addr_q;
          mem_we   = 1'b1;
          if (AUTO_INC) begin
            wr_addr_d = next_addr(wr_addr_q);
          end else begin
            wr_addr_d = wr_addr_q;
          end
        end
        CMD_RD_ADDR: rd_addr_d = din[ADDR_SIZE-1:0];
        CMD_RD_DATA: begin
          dout_d     = mem_rdata;
          tx_valid_d = 1'b1;
          if (AUTO_INC) begin
            rd_addr_d = next_addr(rd_addr_q);
          end else begin
            rd_addr_d = rd_addr_q;
          end
        end
        default: tx_valid_d = 1'b0;
      endcase
    end else begin
      tx_valid_d = 1'b0;
    end
  end

  // Address, read-data and strobe registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q  <= {ADDR_SIZE{1'b0}};
      rd_addr_q  <= {ADDR_SIZE{1'b0}};
      dout_q     <= {DATA_W{1'b0}};
      tx_valid_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  spi_ram_mem #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(din[7:0]),
    .rdata(mem_rdata)
  );

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

endmodule
